incr_arbiter: RTL and testbench

INCR_ARBITER -- requirements
Module: incr_arbiter

---
 rtl/incr_arbiter.sv | 145 ++++++++++++++
 tb/tb_incr_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/incr_arbiter.sv
// Two-requester 32-bit incrementer built around one time-shared 16-bit incrementer (LO half, then HI half).
// Define INCR_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module incr16 (
  input  logic [15:0] x,
  input  logic        c,
  output logic [15:0] s,
  output logic        co
);
  assign s  = x + {15'd0, c};
  assign co = (&x) & c;
endmodule

// rsp handshake: the result transfers in a cycle where rsp_valid && rsp_ready;
// rsp_valid, sum, cout and rsp_id hold steady until that cycle.
module incr_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic        cin0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic        cin1,
  output logic        gnt1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] sum,
  output logic        cout,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] op;
  logic        cin_l;
  logic        carry;
  logic        pick1;
  logic        grant_any;
  logic [15:0] inc_x;
  logic        inc_c;
  logic [15:0] inc_s;
  logic        inc_co;

`ifdef INCR_ARB_RR_EN
  logic ptr;

  // ptr remembers the last winner; on contention the other requester gets it.
  always_comb pick1 = req1 && (!req0 || (ptr == 1'b0));
`else
  always_comb pick1 = req1 && !req0;
`endif

  assign grant_any = (state == IDLE) && !rst && (req0 || req1);
  assign gnt0      = grant_any && !pick1;
  assign gnt1      = grant_any && pick1;
  assign dbg_state = state;

  always_comb begin
    inc_x = op[15:0];
    inc_c = 1'b0;
    case (state)
      LO: begin
        inc_x = op[15:0];
        inc_c = cin_l;
      end
      HI: begin
        inc_x = op[31:16];
        inc_c = carry;
      end
      default: begin
        inc_x = op[15:0];
        inc_c = 1'b0;
      end
    endcase
  end

  incr16 u_inc (
    .x  (inc_x),
    .c  (inc_c),
    .s  (inc_s),
    .co (inc_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= 32'd0;
      cin_l     <= 1'b0;
      carry     <= 1'b0;
      sum       <= 32'd0;
      cout      <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef INCR_ARB_RR_EN
      ptr       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op     <= pick1 ? a1 : a0;
            cin_l  <= pick1 ? cin1 : cin0;
            rsp_id <= pick1;
            busy   <= 1'b1;
            state  <= LO;
`ifdef INCR_ARB_RR_EN
            ptr    <= pick1;
`endif
          end
        end
        LO: begin
          sum[15:0] <= inc_s;
          carry     <= inc_co;
          state     <= HI;
        end
        HI: begin
          sum[31:16] <= inc_s;
          cout       <= inc_co;
          rsp_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_incr_arbiter.sv
// Directed bench for incr_arbiter: per-cycle reference model with an expected-result queue, plus literal checks.
// Honours INCR_ARB_RR_EN the same way as the design for arbitration expectations.

module tb_incr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, cin0, req1, cin1, rsp_ready;
  logic [31:0] a0, a1;
  logic        gnt0, gnt1, rsp_valid, rsp_id, cout, busy;
  logic [31:0] sum;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state: phase counts cycles since grant (0 = idle, 3 = result presented)
  int          m_phase = 0;
  logic        m_last = 1'b1;
  logic [33:0] h_res = 34'd0;
  logic        prev_valid = 1'b0;
  logic [33:0] exp_q[$];

  logic [33:0] act_q[$];
  int          gnt_log[$];
  int          gnt_cyc[$];
  int          hs_cyc[$];
  int          vrise_cyc[$];

  incr_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .cin0(cin0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .cin1(cin1), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .sum(sum), .cout(cout), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model + compare, evaluated mid-cycle when inputs and outputs are settled
  always @(negedge clk) begin
    logic        e0, e1, w;
    logic [32:0] full;
    if (rst) begin
      chk("rst_gnt", {32'd0, gnt1, gnt0}, 34'd0);
      chk("rst_busy", {33'd0, busy}, 34'd0);
      chk("rst_valid", {33'd0, rsp_valid}, 34'd0);
      chk("rst_out", {rsp_id, cout, sum}, 34'd0);
      m_phase = 0;
      m_last = 1'b1;
      h_res = 34'd0;
      prev_valid = 1'b0;
      exp_q.delete();
    end else begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (m_phase == 0 && (req0 || req1)) begin
`ifdef INCR_ARB_RR_EN
        w = (req0 && req1) ? !m_last : req1;
`else
        w = req1 && !req0;
`endif
        e0 = !w;
        e1 = w;
      end
      chk("gnt", {32'd0, gnt1, gnt0}, {32'd0, e1, e0});
      chk("busy", {33'd0, busy}, {33'd0, m_phase != 0});
      chk("rsp_valid", {33'd0, rsp_valid}, {33'd0, m_phase == 3});
      if (m_phase == 0) chk("idle_hold", {rsp_id, cout, sum}, h_res);
      if (m_phase == 3) begin
        if (exp_q.size() > 0) chk("rsp", {rsp_id, cout, sum}, exp_q[0]);
        else chk("rsp_no_expect", 34'd1, 34'd0);
      end
      if (gnt0 || gnt1) begin
        gnt_log.push_back(gnt1 ? 1 : 0);
        gnt_cyc.push_back(cyc);
      end
      if (rsp_valid && !prev_valid) vrise_cyc.push_back(cyc);
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        act_q.push_back({rsp_id, cout, sum});
        hs_cyc.push_back(cyc);
      end
      case (m_phase)
        0: if (e0 || e1) begin
          full = e1 ? ({1'b0, a1} + {32'd0, cin1}) : ({1'b0, a0} + {32'd0, cin0});
          exp_q.push_back({e1, full});
          m_last = e1;
          m_phase = 1;
        end
        1: m_phase = 2;
        2: m_phase = 3;
        default: if (rsp_ready) begin
          if (exp_q.size() > 0) h_res = exp_q.pop_front();
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic id);
    logic got, g;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      g = id ? gnt1 : gnt0;
      tick();
      if (g) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("grant_timeout", 34'd0, 34'd1);
  endtask

  task automatic issue(input logic id, input logic [31:0] a, input logic c);
    if (id) begin req1 = 1'b1; a1 = a; cin1 = c; end
    else begin req0 = 1'b1; a0 = a; cin0 = c; end
    wait_gnt(id);
    if (id) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  task automatic wait_hs();
    logic got, h;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      h = rsp_valid && rsp_ready;
      tick();
      if (h) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("rsp_timeout", 34'd0, 34'd1);
  endtask

  task automatic chk_last(input string name, input logic [33:0] exp);
    if (act_q.size() > 0) chk(name, act_q[act_q.size()-1], exp);
    else chk({name, "_missing"}, 34'd0, 34'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int base, n_act, exp_order[4];
    logic got;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
    a0 = 32'd0; a1 = 32'd0; rsp_ready = 1'b1;
    tick();
    chk("reset_literal", {busy, rsp_valid, rsp_id, cout, sum[29:0]}, 34'd0);
    tick();
    rst = 1'b0;
    tick();

    // carry ripples from the low half into the high half
    issue(1'b0, 32'h0000_FFFF, 1'b1);
    wait_hs();
    chk_last("lo_carry", {1'b0, 1'b0, 32'h0001_0000});
    if (gnt_cyc.size() > 0 && vrise_cyc.size() > 0)
      chk("latency", vrise_cyc[vrise_cyc.size()-1] - gnt_cyc[gnt_cyc.size()-1], 34'd3);
    else chk("latency_missing", 34'd0, 34'd1);

    issue(1'b1, 32'hFFFF_FFFF, 1'b1);
    wait_hs();
    chk_last("wrap", {1'b1, 1'b1, 32'h0000_0000});
    issue(1'b1, 32'hFFFF_FFFF, 1'b0);
    wait_hs();
    chk_last("pass", {1'b1, 1'b0, 32'hFFFF_FFFF});
    issue(1'b0, 32'hABCD_FFFF, 1'b1);
    wait_hs();
    chk_last("mid_carry", {1'b0, 1'b0, 32'hABCE_0000});

    // back-pressure: result held 5 cycles, pending req0 must wait
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0005, 1'b1);
    req0 = 1'b1; a0 = 32'h0000_0007; cin0 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
      tick();
    end
    chk("hold_valid_seen", {33'd0, got}, 34'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("hold_valid", {33'd0, rsp_valid}, 34'd1);
    end
    tick();
    rsp_ready = 1'b1;
    wait_gnt(1'b0);
    req0 = 1'b0;
    if (gnt_cyc.size() > 0 && hs_cyc.size() > 0)
      chk("gnt_after_hs", gnt_cyc[gnt_cyc.size()-1] - hs_cyc[hs_cyc.size()-1], 34'd1);
    else chk("gnt_after_hs_missing", 34'd0, 34'd1);
    chk_last("held_result", {1'b0, 1'b0, 32'h0000_0006});
    wait_hs();
    chk_last("after_hold", {1'b0, 1'b0, 32'h0000_0007});

    // contention for four operations from a fresh reset
    do_reset();
    tick();
    base = gnt_log.size();
    req0 = 1'b1; a0 = 32'h0000_0001; cin0 = 1'b1;
    req1 = 1'b1; a1 = 32'h0000_0002; cin1 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt_log.size() >= base + 4) break;
      tick();
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    wait_hs();
`ifdef INCR_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      if (gnt_log.size() > base + i) chk("grant_order", gnt_log[base+i], exp_order[i]);
      else chk("grant_order_missing", 34'd0, 34'd1);
    end
    if (gnt_cyc.size() > base + 1)
      chk("throughput", gnt_cyc[base+1] - gnt_cyc[base], 34'd4);
    else chk("throughput_missing", 34'd0, 34'd1);

    // abort during the high-half cycle
    tick();
    issue(1'b0, 32'h1234_5678, 1'b1);
    tick();
    n_act = act_q.size();
    rst = 1'b1;
    #1;
    chk("abort_outputs", {busy, rsp_valid, gnt0, gnt1, cout, rsp_id, sum[27:0]}, 34'd0);
    chk("abort_sum", {2'd0, sum}, 34'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_no_rsp", act_q.size(), n_act);
    issue(1'b0, 32'h1234_5678, 1'b1);
    wait_hs();
    chk_last("after_abort", {1'b0, 1'b0, 32'h1234_5679});

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
